fixed_point_addsub_pipe: RTL and testbench
==========================================

Name: fixed_point_addsub_pipe

Overview:
- Pipelined signed fixed-point adder/subtractor with valid/ready handshakes on both sides.
- Acts as the streaming consumer/producer counterpart to the registered data passthrough in the DSP filter datapath.
- Accepts operand pairs plus an add/sub select, computes at full precision, then saturates (or wraps) to the input format.
- Used as the building block for filter tap summation.

Parameters:
- DATA_W, 8: operand and result width in bits, signed two's complement.
- FRAC_W, 4: fractional bits of the Q(DATA_W-FRAC_W).FRAC_W format. Inputs and output share this format, so no shift is applied. Informational only; legal range 0..DATA_W-1.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream operand pair valid.
- o_ready  output  1  block can accept an operand pair this cycle.
- i_a  input  DATA_W  operand A, signed.
- i_b  input  DATA_W  operand B, signed.
- i_sub  input  1  0: A+B, 1: A-B; sampled with the operands.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream can accept the result.
- o_data  output  DATA_W  result, signed, same Q format as the inputs.
- o_overflow  output  1  the full-precision result did not fit in DATA_W bits; qualified by o_valid.

Behaviour:
- Reset: i_clk single clock domain; i_reset is asynchronous and active-high. While i_reset is high, all state clears immediately: s1_valid=0, s2_valid=0, o_valid=0, o_data=0, o_overflow=0.
- Reset mid-operation: in-flight operands are discarded; nothing is replayed after reset releases.
- Handshake: a transfer occurs on any cycle where valid && ready. Once o_valid is asserted, o_data and o_overflow hold stable until i_ready=1. o_valid never drops without a transfer (except on reset).
- Stage 1 (S1): on acceptance, sign-extend i_a and i_b to DATA_W+1 bits and register s1_sum = i_sub ? a-b : a+b. Set s1_valid.
- Stage 2 (S2, output register): ovf = (s1_sum[DATA_W] != s1_sum[DATA_W-1]). Register o_data and o_overflow=ovf, and set o_valid.
- Advance rules:
  - s2_adv = !o_valid || i_ready.
  - s1_adv = s1_valid && s2_adv.
  - o_ready = !s1_valid || s2_adv.
  - The combinational path from i_ready to o_ready is intentional.
  - When o_valid && i_ready && !s1_valid, o_valid clears next cycle.
- Latency: 2 cycles from accept to o_valid with no backpressure. Throughput: 1 result per cycle.
- Backpressure: the block holds at most 2 pairs (S1 plus S2). With i_ready=0, o_ready deasserts once both stages are full.
- Ordering: results leave strictly in acceptance order; no drops, no duplicates.
- Simultaneous events: S2 output transfer and S1->S2 advance in the same cycle are allowed, as is a new accept into S1 in that same cycle.
- Boundaries:
  - Most-negative minus most-negative gives 0 with no overflow.
  - 0 minus most-negative overflows positive.

Optional Feature:
- Macro FIXED_POINT_SAT_EN.
- Defined: on ovf, o_data saturates. Positive overflow (s1_sum[DATA_W]=0) gives 0x7F..F; negative overflow gives 0x80..0.
- Undefined: o_data = s1_sum[DATA_W-1:0] (modulo wrap).
- o_overflow is reported identically in both builds.

Test Plan:
- Basic add: DATA_W=8, i_a=0x30 (3.0), i_b=0x20 (2.0), i_sub=0, i_ready=1. Expect o_valid exactly 2 cycles after accept, o_data=0x50, o_overflow=0.
- Subtract to negative: i_a=0x10, i_b=0x30, i_sub=1. Expect o_data=0xE0, o_overflow=0.
- Positive overflow: i_a=0x70, i_b=0x20, add. Expect o_overflow=1; o_data=0x7F with FIXED_POINT_SAT_EN, 0x90 without.
- Negative overflow: i_a=0x80, i_b=0x01, i_sub=1. Expect o_overflow=1; o_data=0x80 with the macro, 0x7F without. Also 0x00-0x80 sub: o_overflow=1, 0x7F with the macro, 0x80 without.
- Backpressure: stream 5 pairs back-to-back with i_ready=0 for 4 cycles.
  - o_ready drops after 2 accepts.
  - o_data is held stable.
  - After i_ready=1, all 5 results appear in order, 1 per cycle, none lost.
- Reset mid-flight: assert i_reset asynchronously between clock edges with both stages full. Expect o_valid=0, o_data=0 and o_ready=1 immediately; no stale result after release.

Source files
------------

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage signed fixed-point add/sub with valid/ready on both sides.
// Optional macro FIXED_POINT_SAT_EN: saturate o_data on overflow instead of wrapping.
module fixed_point_addsub_pipe #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow
);

  // Q format is shared by inputs and output, so FRAC_W only needs a range check.
  if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
    $error("FRAC_W must be in 0..DATA_W-1");
  end

  logic              s1_valid;
  logic [DATA_W:0]   s1_sum;
  logic              s2_adv;
  logic              s1_adv;
  logic              accept;
  logic [DATA_W:0]   a_ext;
  logic [DATA_W:0]   b_ext;
  logic              ovf;
  logic [DATA_W-1:0] result;

  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = s1_valid && s2_adv;
  // i_ready reaches o_ready combinationally so a full pipe can still stream.
  assign o_ready = !s1_valid || s2_adv;
  assign accept  = i_valid && o_ready;

  assign a_ext = {i_a[DATA_W-1], i_a};
  assign b_ext = {i_b[DATA_W-1], i_b};

  assign ovf = (s1_sum[DATA_W] != s1_sum[DATA_W-1]);

`ifdef FIXED_POINT_SAT_EN
  always_comb begin
    result = s1_sum[DATA_W-1:0];
    if (ovf) begin
      result = s1_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign result = s1_sum[DATA_W-1:0];
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sum   <= i_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else if (s1_adv) begin
      o_valid    <= 1'b1;
      o_data     <= result;
      o_overflow <= ovf;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Directed and random checks of fixed_point_addsub_pipe against an arithmetic model.
// Build with or without FIXED_POINT_SAT_EN; expectations follow the same macro.
module tb_fixed_point_addsub_pipe;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       i_sub;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_overflow;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  logic last_acc;
  logic last_xfer;

  fixed_point_addsub_pipe #(.DATA_W(8), .FRAC_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference: exact integer result, then range check and wrap/saturate.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int sa, sb, full;
    logic ov;
    logic [7:0] d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = sub ? sa - sb : sa + sb;
    ov = (full > 127) || (full < -128);
    d = full[7:0];
`ifdef FIXED_POINT_SAT_EN
    if (ov) d = (full > 0) ? 8'h7F : 8'h80;
`endif
    return {ov, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, note transfers, scoreboard outputs, advance one clock.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic rdy);
    logic [8:0] e;
    i_valid = v; i_a = a; i_b = b; i_sub = sub; i_ready = rdy;
    #1;
    last_acc  = i_valid && o_ready;
    last_xfer = o_valid && i_ready;
    if (last_xfer) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {23'd0, o_overflow, o_data}, 32'h1FF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, o_data}, {24'd0, e[7:0]});
        chk("sb_ovf", {31'd0, o_overflow}, {31'd0, e[8]});
      end
    end
    if (last_acc) exp_q.push_back(model(a, b, sub));
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] ed, input logic eo);
    step(1'b1, a, b, sub, 1'b1);
    chk({tag, "_acc"}, {31'd0, last_acc}, 32'd1);
    chk({tag, "_lat1"}, {31'd0, o_valid}, 32'd0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk({tag, "_lat2"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, o_data}, {24'd0, ed});
    chk({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, eo});
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk({tag, "_drain"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] pa[5];
    logic [7:0] pb[5];
    logic [7:0] held;
    int idx, outs, first_out, cyc;

    i_reset = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0; i_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    i_reset = 1'b0;
    @(negedge i_clk);

    run_one("add", 8'h30, 8'h20, 1'b0, 8'h50, 1'b0);
    run_one("subneg", 8'h10, 8'h30, 1'b1, 8'hE0, 1'b0);
`ifdef FIXED_POINT_SAT_EN
    run_one("posovf", 8'h70, 8'h20, 1'b0, 8'h7F, 1'b1);
    run_one("negovf", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1);
    run_one("zero_minus_min", 8'h00, 8'h80, 1'b1, 8'h7F, 1'b1);
`else
    run_one("posovf", 8'h70, 8'h20, 1'b0, 8'h90, 1'b1);
    run_one("negovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
    run_one("zero_minus_min", 8'h00, 8'h80, 1'b1, 8'h80, 1'b1);
`endif
    run_one("min_minus_min", 8'h80, 8'h80, 1'b1, 8'h00, 1'b0);

    // Backpressure: 5 pairs offered back-to-back, i_ready low for 4 cycles.
    for (int i = 0; i < 5; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    idx = 0; outs = 0; first_out = -1; held = 8'h00;
    for (cyc = 0; cyc < 20 && outs < 5; cyc++) begin
      if (cyc == 3) chk("bp_hold_data", {24'd0, o_data}, {24'd0, held});
      step(idx < 5, (idx < 5) ? pa[idx] : 8'h00, (idx < 5) ? pb[idx] : 8'h00,
           idx[0], cyc >= 4);
      if (cyc == 2) begin
        chk("bp_ready_low", {31'd0, last_acc}, 32'd0);
        held = o_data;
      end
      if (cyc == 3) chk("bp_ready_low2", {31'd0, last_acc}, 32'd0);
      if (last_acc) idx++;
      if (last_xfer) begin
        if (first_out < 0) first_out = cyc;
        outs++;
      end
    end
    chk("bp_two_accepts_then_all", {26'd0, 6'(idx)}, 32'd5);
    chk("bp_all_out", {26'd0, 6'(outs)}, 32'd5);
    chk("bp_one_per_cycle", 32'(cyc - first_out), 32'd5);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset between edges with both stages full.
    step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
    chk("full_valid", {31'd0, o_valid}, 32'd1);
    chk("full_ready", {31'd0, o_ready}, 32'd0);
    #2 i_reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, o_data}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    exp_q.delete();
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      chk("post_rst_no_stale", {31'd0, o_valid}, 32'd0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           1'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 10 && (exp_q.size() != 0 || o_valid); i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_idle", {31'd0, o_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
